serial_port: RTL and testbench

- Memory-mapped byte serial peripheral on the CPU's shared 16-bit bus, addressed by `addr`.
- Responds to the CPU's device strobes:
  - DI: the CPU writes the bus to the device.
  - DO: the device drives the bus.
- Serialises bytes written by the CPU onto `tx` as 8N1 frames through a small TX FIFO.
- Deserialises 8N1 frames from `rx` into a one-byte holding register that the CPU reads.

---
 rtl/serial_port.sv | 267 ++++++++++++++++++++++++++
 tb/tb_serial_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port.sv
// serial_port: memory-mapped byte serial peripheral on a shared 16-bit bus.
//   Data register at BASE:
//     - A write enqueues bus[7:0] into the TX FIFO.
//     - A read returns {8'h00, rxbuf} and clears rx_avail.
//   Status register at BASE+1:
//     - Read: {11'h0, loop, tx_busy, overrun, tx_notfull, rx_avail}.
//     - Write with bus[2]=1 clears overrun.
//   TX sends 8N1 frames LSB first, CLKDIV clocks per bit, from a TXDEPTH FIFO.
//   RX samples a 2-flop synchronised line mid-bit into a one-byte holding register.
// Ports:
//   clk      system clock (rising edge)
//   RST      synchronous reset, active high
//   addr     device address from CPU
//   bus      shared data bus, driven only on a selected DO cycle
//   DI / DO  CPU write / read strobes (one cycle per access)
//   tx       serial output, idle high
//   rx       serial input, asynchronous, idle high
//   loop     (SERIAL_LOOPBACK_EN only) route internal tx into the RX path
// Optional feature macro: SERIAL_LOOPBACK_EN adds the loop port and status bit 4.
module serial_port #(
  parameter logic [15:0] BASE    = 16'd136,
  parameter int          CLKDIV  = 16,
  parameter int          TXDEPTH = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] addr,
  inout  wire  [15:0] bus,
  input  logic        DI,
  input  logic        DO,
  output logic        tx,
  input  logic        rx
`ifdef SERIAL_LOOPBACK_EN
  ,
  input  logic        loop
`endif
);

  localparam int PW = $clog2(TXDEPTH);
  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKDIV / 2 - 1);

  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;

  // ---------------- address decode ----------------
  logic sel_data, sel_stat, wr_data, rd_data, wr_stat;
  assign sel_data = (addr == BASE);
  assign sel_stat = (addr == BASE + 16'd1);
  assign wr_data  = DI & sel_data;
  assign rd_data  = DO & sel_data;
  assign wr_stat  = DI & sel_stat;

  // Upper write-data bits are ignored by every register.
  logic unused_bus_hi;
  assign unused_bus_hi = ^bus[15:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_q [TXDEPTH];
  logic [PW:0] wptr_q, rptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [1:0]  tx_state_q, tx_state_d;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  // Pop is decided from registered state only, so a byte written into an
  // empty FIFO is popped one cycle later (no bypass).
  assign pop  = (tx_state_q == TX_IDLE) & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the write.
  assign push = wr_data & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PW-1:0]] <= bus[7:0];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_END);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (pop) begin
          tx_shift_d = fifo_q[rptr_q[PW-1:0]];
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      default: begin
        if (tx_bit_end) tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Line level decoded from state so a reset forces idle-high on the next cycle.
  always_comb begin
    case (tx_state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  // ---------------- RX path ----------------
  logic rx_src, sync1_q, sync2_q, prev_q;
`ifdef SERIAL_LOOPBACK_EN
  assign rx_src = loop ? tx : rx;
`else
  assign rx_src = rx;
`endif

  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          deliver;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    deliver    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (prev_q & ~sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: re-check the line to reject glitches.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = 3'd0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          deliver    = sync2_q;  // a low stop bit is a framing error: drop
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      sync1_q    <= rx_src;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- holding register / status ----------------
  logic [7:0] rxbuf_q, rxbuf_d;
  logic       rx_avail_q, rx_avail_d, overrun_q, overrun_d;

  always_comb begin
    rxbuf_d    = rxbuf_q;
    rx_avail_d = rx_avail_q;
    overrun_d  = overrun_q;
    if (rd_data) rx_avail_d = 1'b0;
    if (wr_stat & bus[2]) overrun_d = 1'b0;
    if (deliver) begin
      // A read in the same cycle frees the buffer: the reader sees the old
      // byte and the new one is kept without flagging overrun.
      if (~rx_avail_q | rd_data) begin
        rxbuf_d    = rx_shift_q;
        rx_avail_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rxbuf_q    <= '0;
      rx_avail_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxbuf_q    <= rxbuf_d;
      rx_avail_q <= rx_avail_d;
      overrun_q  <= overrun_d;
    end
  end

  logic        loop_bit, tx_busy;
  logic [15:0] rdata;
`ifdef SERIAL_LOOPBACK_EN
  assign loop_bit = loop;
`else
  assign loop_bit = 1'b0;
`endif
  assign tx_busy = (tx_state_q != TX_IDLE) | ~fifo_empty;
  assign rdata   = sel_data ? {8'h00, rxbuf_q}
                            : {11'h000, loop_bit, tx_busy, overrun_q, ~fifo_full, rx_avail_q};
  assign bus     = (DO & (sel_data | sel_stat)) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_serial_port.sv
module tb_serial_port;
  localparam logic [15:0] BASE = 16'd136;
  localparam logic [15:0] STAT = BASE + 16'd1;
  localparam int C = 16;
  localparam int D = 4;

  logic clk = 1'b0, RST = 1'b1, DI = 1'b0, DO = 1'b0, rx = 1'b1, drv_en = 1'b0;
  logic [15:0] addr = '0, drv = '0;
  wire  [15:0] bus;
  logic tx;
`ifdef SERIAL_LOOPBACK_EN
  logic loop = 1'b0;
`endif

  assign bus = drv_en ? drv : 16'hzzzz;
  always #5 clk = ~clk;

  serial_port #(.BASE(BASE), .CLKDIV(C), .TXDEPTH(D)) dut (
    .clk(clk), .RST(RST), .addr(addr), .bus(bus), .DI(DI), .DO(DO), .tx(tx), .rx(rx)
`ifdef SERIAL_LOOPBACK_EN
    , .loop(loop)
`endif
  );

  int checks = 0, errors = 0;

  // Reference model: byte queue plus the time the transmitter next goes idle.
  logic [7:0]  mq[$];
  int          tx_free = 0, cyc = 0;
  logic [7:0]  m_rxbuf = '0;
  bit          m_avail = 0, m_ovr = 0;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  lb_q[$];
  int          lb_t[$];

  function automatic bit m_busy();
    return (mq.size() != 0) || (cyc < tx_free);
  endfunction

  function automatic logic [15:0] m_status();
    logic lb;
`ifdef SERIAL_LOOPBACK_EN
    lb = loop;
`else
    lb = 1'b0;
`endif
    return {11'h000, lb, m_busy(), m_ovr, (mq.size() < D), m_avail};
  endfunction

  function automatic void m_deliver(logic [7:0] b);
    if (!m_avail) begin m_rxbuf = b; m_avail = 1; end
    else m_ovr = 1;
  endfunction

  // Advance the model over the coming clock edge, then step the clock.
  task automatic tick();
    logic [7:0] b;
    if (RST) begin
      mq.delete(); exp_tx.delete(); lb_q.delete(); lb_t.delete();
      tx_free = 0; m_rxbuf = '0; m_avail = 0; m_ovr = 0;
    end else begin
      if (mq.size() != 0 && cyc >= tx_free) begin
        b = mq.pop_front();
        exp_tx.push_back(b);
        tx_free = cyc + 1 + 10 * C;  // frame = start + 8 data + stop bits
`ifdef SERIAL_LOOPBACK_EN
        if (loop) begin lb_q.push_back(b); lb_t.push_back(tx_free); end
`endif
      end
      if (DI && addr == BASE && mq.size() < D) mq.push_back(drv[7:0]);
      if (DI && addr == STAT && drv[2]) m_ovr = 0;
      if (DO && addr == BASE) m_avail = 0;
      if (lb_t.size() != 0 && cyc + 1 >= lb_t[0]) begin
        void'(lb_t.pop_front());
        m_deliver(lb_q.pop_front());
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [15:0] a);
    addr = a; DO = 1'b1;
    if (a == BASE) exp_rd.push_back({8'h00, m_rxbuf});
    else if (a == STAT) exp_rd.push_back(m_status());
    tick();
    DO = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; drv = d; drv_en = 1'b1; DI = 1'b1;
    tick();
    DI = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int k = 0; k < 10; k++) begin rx = f[k]; idle(C); end
    rx = 1'b1;
    idle(4);
    if (good) m_deliver(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000 && m_busy(); i++) tick();
    idle(4);
  endtask

  // Bus-read scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (DO && (addr == BASE || addr == STAT)) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++; $display("FAIL bus_read: unexpected read got %h", bus);
      end else begin
        e = exp_rd.pop_front();
        if (bus !== e) begin
          errors++; $display("FAIL bus_read addr=%h: got %h expected %h", addr, bus, e);
        end
      end
    end
  end

  // TX line monitor: decode frames at mid-bit, compare to model's byte order.
  bit         m_act = 0;
  int         m_n = 0;
  logic [7:0] m_sh = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (RST) m_act = 0;
    else if (!m_act) begin
      if (tx == 1'b0) begin m_act = 1; m_n = 0; end
    end else m_n++;
    if (m_act && !RST) begin
      if (m_n == C / 2 && tx !== 1'b0) begin
        checks++; errors++; $display("FAIL tx_start: got %b expected 0", tx);
        m_act = 0;
      end else if (m_n >= C + C / 2 && m_n <= 8 * C + C / 2 && (m_n - C / 2) % C == 0)
        m_sh = {tx, m_sh[7:1]};
      else if (m_n == 9 * C + C / 2) begin
        m_act = 0;
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL tx_byte: unexpected frame got %h", m_sh);
        end else begin
          e = exp_tx.pop_front();
          if (tx !== 1'b1 || m_sh !== e) begin
            errors++; $display("FAIL tx_byte: got %h stop=%b expected %h stop=1", m_sh, tx, e);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    RST = 1'b1; idle(3); RST = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    rd(STAT); rd(BASE); idle(2);

    // Single frame with status during and after
    wr(BASE, 16'hAB55); idle(5); rd(STAT);
    wait_idle(); rd(STAT);

    // Fill FIFO while the transmitter is busy; the fifth byte is dropped
    wr(BASE, 16'h00AA); idle(3);
    for (int i = 1; i <= 5; i++) wr(BASE, 16'(i));
    rd(STAT);
    wait_idle(); rd(STAT);

    // Receive, read, status
    rx_frame(8'hC3, 1); rd(STAT); rd(BASE); rd(STAT);

    // Overrun and clear
    rx_frame(8'h11, 1); rx_frame(8'h22, 1);
    rd(BASE); rd(STAT); wr(STAT, 16'h0004); rd(STAT);

    // Framing error is discarded
    rx_frame(8'h7E, 0); rd(STAT); rd(BASE);

    // Reset in the middle of a frame
    wr(BASE, 16'h003C); idle(3 * C);
    RST = 1'b1; tick(); RST = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_midframe_tx: got %b expected 1", tx); end
    rd(STAT); idle(12 * C);

`ifdef SERIAL_LOOPBACK_EN
    loop = 1'b1; idle(2);
    wr(BASE, 16'h005A); wait_idle(); idle(4);
    rd(STAT); rd(BASE);
    loop = 1'b0; idle(2);
`endif

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 6))
        0: wr(BASE, 16'($urandom));
        1: rd(STAT);
        2: rd(BASE);
        3: rx_frame(8'($urandom), $urandom_range(0, 4) != 0);
        4: wr(STAT, 16'($urandom));
        5: idle($urandom_range(1, 40));
        default: begin
          if ($urandom_range(0, 1) != 0) wr(BASE + 16'd2 + 16'($urandom_range(0, 50)), 16'($urandom));
          else rd(BASE - 16'd1 - 16'($urandom_range(0, 50)));
        end
      endcase
    end
    wait_idle(); rd(STAT); rd(BASE); rd(STAT);
    idle(4);

    checks++;
    if (exp_tx.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL drain: got tx_pending=%0d rd_pending=%0d expected 0", exp_tx.size(), exp_rd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
